puvvada_btn_capture: RTL and testbench
======================================

// Module: puvvada_btn_capture
// PURPOSE
// - Input-side counterpart to the SSD output path: turns raw BtnU/BtnR/BtnD/BtnL into debounced, one-per-press colour events.
// - Sits between the board buttons and puvvada_says_sm. Each accepted press is delivered once through a valid/ack handshake.
// - Runs on board_clk (100 MHz). The slow-clocked game SM takes each event by asserting color_ack.
// PARAMETERS
// - DEBOUNCE_CYCLES  1_000_000  stable cycles required to accept a press or a release (10 ms @100 MHz); minimum 2
// - FIFO_DEPTH       4          event buffer depth, power of 2; used only when PUVVADA_BTN_FIFO_EN is defined
// PORTS
// - board_clk    in   1  system clock, 100 MHz
// - reset        in   1  asynchronous, active-high
// - btn_u        in   1  raw Up button, asynchronous
// - btn_r        in   1  raw Right button, asynchronous
// - btn_d        in   1  raw Down button, asynchronous
// - btn_l        in   1  raw Left button, asynchronous
// - enable       in   1  game ON (Sw0); low = capture disabled and buffer flushed
// - color_ack    in   1  consumer accepts the current event
// - color_valid  out  1  an event is pending
// - color_code   out  2  colour of the pending event: U=0, R=1, D=2, L=3
// - overrun      out  1  sticky; an event was dropped
// - busy         out  1  FSM is not in IDLE
// BEHAVIOUR
// - Reset and interface:
//   - reset and enable are stated as decided: reset reset, asynchronous, active-high; clock board_clk.
//   - On reset: all outputs 0, FSM = IDLE, counter = 0, buffer empty, synchronisers = 0.
// - Input synchroniser: 2-flop synchroniser per button. Decisions use the 4-bit synced vector s = {l,d,r,u}.
// - FSM states: IDLE, QUAL, HELD, RELQ. Unsigned counter cnt is $clog2(DEBOUNCE_CYCLES) bits wide.
//   - IDLE: if s is one-hot, latch cand = s, set cnt = 0, go to QUAL. Zero buttons or several buttons: stay in IDLE.
//   - QUAL: if s != cand, go to IDLE (cnt cleared). Otherwise cnt increments.
//     When cnt == DEBOUNCE_CYCLES-1, push encode(cand) and go to HELD.
//   - HELD: if s == 0, set cnt = 0 and go to RELQ. Any other change (extra or swapped button) stays in HELD with no new event.
//   - RELQ: if s != 0, go back to HELD. Otherwise cnt increments.
//     When cnt == DEBOUNCE_CYCLES-1, go to IDLE.
//   - Net rule: one event per press-release cycle. A new press is recognised only after a debounced release.
// - Latency: pin stable at cycle t0 → color_valid high at t0 + 2 + DEBOUNCE_CYCLES + 1.
// - Handshake:
//   - color_code is stable while color_valid is high.
//   - A pop happens on any edge where color_valid && color_ack.
//   - color_ack while color_valid is low is ignored.
//   - Push and pop in the same cycle are both honoured; color_valid stays high if data remains.
// - enable low (asynchronous to game, sampled on board_clk):
//   - Next edge: FSM = IDLE, buffer flushed, color_valid = 0, overrun = 0.
//   - Held pins are ignored until they are released and re-pressed after enable returns high.
// - Reset mid-debounce or mid-handshake: everything returns to reset values. No event is emitted.
// CONFIGURATION
// - Macro PUVVADA_BTN_FIFO_EN defined:
//   - Events go into a FIFO_DEPTH circular FIFO; pointers are $clog2(FIFO_DEPTH)+1 bits and wrap.
//   - Push when full without a simultaneous pop: event dropped, overrun set.
//   - Push with pop when full: accepted.
// - Macro not defined:
//   - Single holding register.
//   - Push while color_valid=1 and color_ack=0: event dropped, overrun set.
//   - Push with ack in the same cycle: the register reloads and color_valid stays high.
// STRUCTURE
// - Package puvvada_says_pkg holds:
//   - colour constants COLOR_U=2'd0, COLOR_R=2'd1, COLOR_D=2'd2, COLOR_L=2'd3;
//   - FSM state encodings;
//   - one-hot → colour encode function (shared with the game SM and the VGA colour lookup).
// - One sub-module: puvvada_evt_fifo (parameterised depth, push/pop/full/empty). It is instantiated only under PUVVADA_BTN_FIFO_EN.
// TESTING (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4)
// - btn_r high for 20 cycles, ack tied high → exactly one event, color_code=1. color_valid first rises 7 cycles after btn_r.
// - btn_u bounces (1,0,1,0 every cycle), then stays stable high → one event, color_code=0. None is emitted during the bounce.
// - btn_u and btn_l high together for 20 cycles → no event, busy=0 throughout.
// - Macro off, ack=0: press D, release, press L → color_code=2 is held, overrun=1. One ack → color_valid=0.
// - Macro on, ack=0: five presses U,R,D,L,U → overrun=1. Acks pop 0,1,2,3, then color_valid=0.
// - Press U and reach HELD, pulse reset mid-hold → all outputs 0. No event appears after reset is released with the button still held.

Source files
------------

// File: rtl/puvvada_says_pkg.sv
// Shared definitions for the Puvvada Says game: colour codes, button
// capture FSM states and the one-hot button to colour encoder.
package puvvada_says_pkg;

    typedef logic [1:0] color_t;

    localparam color_t COLOR_U = 2'd0;
    localparam color_t COLOR_R = 2'd1;
    localparam color_t COLOR_D = 2'd2;
    localparam color_t COLOR_L = 2'd3;

    // Button capture FSM: wait for press, qualify press, pressed, qualify release.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_QUAL = 2'd1,
        ST_HELD = 2'd2,
        ST_RELQ = 2'd3
    } btn_state_t;

    // Button vector ordering is {l, d, r, u}.
    function automatic color_t onehot_to_color(input logic [3:0] oh);
        color_t c;
        c = COLOR_U;
        case (oh)
            4'b0010: c = COLOR_R;
            4'b0100: c = COLOR_D;
            4'b1000: c = COLOR_L;
            default: c = COLOR_U;
        endcase
        return c;
    endfunction

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/puvvada_btn_capture_if.sv
// Colour event handshake between the button capture block (master) and the
// game state machine (slave). An event is taken on an edge where
// color_valid && color_ack.
interface puvvada_btn_capture_if;
    import puvvada_says_pkg::*;

    logic   color_valid;
    color_t color_code;
    logic   color_ack;

    modport master (
        output color_valid,
        output color_code,
        input  color_ack
    );

    modport slave (
        input  color_valid,
        input  color_code,
        output color_ack
    );

endinterface

// File: rtl/puvvada_evt_fifo.sv
// Small circular FIFO for colour events. Pointers carry one extra wrap bit so
// full and empty are distinguished without a counter. A write into a full FIFO
// is accepted when a read happens on the same edge. flush empties it
// synchronously.
module puvvada_evt_fifo
    import puvvada_says_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   flush,
    input  logic   push,
    input  logic   pop,
    input  color_t din,
    output color_t dout,
    output logic   full,
    output logic   empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    color_t        mem [DEPTH];
    logic          do_rd;
    logic          do_wr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd = pop && !empty;
    assign do_wr = push && (!full || do_rd);
    assign dout  = empty ? COLOR_U : mem[rd_ptr[AW-1:0]];

    // Pointer update; flush discards all stored events.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PW'(1);
            if (do_rd) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Event storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (do_wr && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/puvvada_btn_capture.sv
// Button capture: synchronises BtnU/BtnR/BtnD/BtnL, debounces press and
// release, and delivers exactly one colour event per press-release cycle over
// a valid/ack handshake.
// Optional feature macro: PUVVADA_BTN_FIFO_EN selects a FIFO_DEPTH event FIFO
// instead of the single holding register.
module puvvada_btn_capture
    import puvvada_says_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                         board_clk,
    input  logic                         reset,
    input  logic                         btn_u,
    input  logic                         btn_r,
    input  logic                         btn_d,
    input  logic                         btn_l,
    input  logic                         enable,
    puvvada_btn_capture_if.master        evt,
    output logic                         overrun,
    output logic                         busy
);

    localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("puvvada_btn_capture: DEBOUNCE_CYCLES >= 2 and power-of-2 FIFO_DEPTH >= 2 required");
    end

    logic [3:0]       sync1;
    logic [3:0]       s;
    logic [1:0]       prime_sr;
    logic             armed;
    btn_state_t       state;
    btn_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [3:0]       cand;
    logic [3:0]       cand_nxt;
    logic             evt_push;
    color_t           evt_code;
    logic             pop;

    // Two-flop synchroniser for the raw button pins, vector order {l,d,r,u}.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            s     <= '0;
        end else begin
            sync1 <= {btn_l, btn_d, btn_r, btn_u};
            s     <= sync1;
        end
    end

    // A press is only accepted after an all-released vector has been seen
    // through a filled synchroniser since reset or since enable was low, so a
    // button held across reset or enable toggling yields no event.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            prime_sr <= '0;
            armed    <= 1'b0;
        end else begin
            prime_sr <= {prime_sr[0], 1'b1};
            if (!enable)
                armed <= 1'b0;
            else if (prime_sr[1] && (s == 4'b0000))
                armed <= 1'b1;
        end
    end

    // Debounce FSM state, counter and candidate button register.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            cand  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            cand  <= cand_nxt;
        end
    end

    // Debounce FSM next state; push fires on the last stable press cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cand_nxt  = cand;
        evt_push  = 1'b0;
        if (!enable) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (armed && is_onehot(s)) begin
                        cand_nxt  = s;
                        cnt_nxt   = '0;
                        state_nxt = ST_QUAL;
                    end
                end
                ST_QUAL: begin
                    if (s != cand) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end else if (cnt == CNT_MAX) begin
                        evt_push  = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = ST_HELD;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ST_HELD: begin
                    if (s == 4'b0000) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_RELQ;
                    end
                end
                ST_RELQ: begin
                    if (s != 4'b0000) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_HELD;
                    end else if (cnt == CNT_MAX) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign evt_code = onehot_to_color(cand);
    assign busy     = (state != ST_IDLE);
    assign pop      = evt.color_valid && evt.color_ack;

`ifdef PUVVADA_BTN_FIFO_EN
    logic   fifo_full;
    logic   fifo_empty;
    color_t fifo_dout;

    puvvada_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk   (board_clk),
        .reset (reset),
        .flush (!enable),
        .push  (evt_push),
        .pop   (pop),
        .din   (evt_code),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign evt.color_valid = !fifo_empty;
    assign evt.color_code  = fifo_dout;

    // Sticky drop flag: push into a full FIFO with no pop on the same edge.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset)
            overrun <= 1'b0;
        else if (!enable)
            overrun <= 1'b0;
        else if (evt_push && fifo_full && !pop)
            overrun <= 1'b1;
    end
`else
    logic   hold_valid;
    color_t hold_code;

    assign evt.color_valid = hold_valid;
    assign evt.color_code  = hold_code;

    // Single holding register; a push with a same-edge pop reloads it.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_code  <= COLOR_U;
            overrun    <= 1'b0;
        end else if (!enable) begin
            hold_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (evt_push) begin
            if (!hold_valid || pop) begin
                hold_code  <= evt_code;
                hold_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_puvvada_btn_capture.sv
// Self-checking bench for puvvada_btn_capture with DEBOUNCE_CYCLES=4 and
// FIFO_DEPTH=4. A sample-count model of the debounce rules plus an event queue
// predicts the outputs every cycle; directed scenarios add literal checks.
module tb_puvvada_btn_capture;
    import puvvada_says_pkg::*;

    localparam int DEB = 4;
`ifdef PUVVADA_BTN_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic board_clk = 1'b0;
    logic reset     = 1'b1;
    logic btn_u     = 1'b0;
    logic btn_r     = 1'b0;
    logic btn_d     = 1'b0;
    logic btn_l     = 1'b0;
    logic enable    = 1'b1;
    logic overrun;
    logic busy;

    puvvada_btn_capture_if evt_if ();

    puvvada_btn_capture #(
        .DEBOUNCE_CYCLES (DEB),
        .FIFO_DEPTH      (4)
    ) dut (
        .board_clk (board_clk),
        .reset     (reset),
        .btn_u     (btn_u),
        .btn_r     (btn_r),
        .btn_d     (btn_d),
        .btn_l     (btn_l),
        .enable    (enable),
        .evt       (evt_if),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 board_clk = ~board_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0] m_p1, m_p2;
    int         m_prime;
    bit         m_need_rel;
    int         m_run;      // matching press samples so far, 0 = not qualifying
    logic [3:0] m_cand;
    bit         m_down;     // press accepted, release not yet debounced
    int         m_quiet;    // consecutive all-released samples while down
    color_t     m_q[$];
    bit         m_ovr;

    function automatic color_t color_of(input logic [3:0] v);
        color_t c;
        c = 0;
        for (int i = 0; i < 4; i++)
            if (v[i]) c = color_t'(i);
        return c;
    endfunction

    task automatic model_reset();
        m_p1 = 0; m_p2 = 0; m_prime = 0; m_need_rel = 1;
        m_run = 0; m_cand = 0; m_down = 0; m_quiet = 0;
        m_q.delete(); m_ovr = 0;
    endtask

    task automatic model_step();
        logic [3:0] s;
        bit         pop, push, armed_old;
        color_t     pc;
        s         = m_p2;
        armed_old = !m_need_rel;
        pop       = (m_q.size() != 0) && evt_if.color_ack;
        push      = 0;
        pc        = 0;
        if (!enable) begin
            m_q.delete(); m_ovr = 0; m_run = 0; m_down = 0; m_quiet = 0; m_need_rel = 1;
        end else begin
            if (m_prime >= 2 && s == 0) m_need_rel = 0;
            if (m_down) begin
                if (s != 0) m_quiet = 0;
                else begin
                    m_quiet++;
                    if (m_quiet == DEB + 1) begin m_down = 0; m_quiet = 0; end
                end
            end else if (m_run > 0) begin
                if (s != m_cand) m_run = 0;
                else begin
                    m_run++;
                    if (m_run == DEB + 1) begin
                        push = 1; pc = color_of(m_cand); m_down = 1; m_run = 0;
                    end
                end
            end else if (armed_old && $countones(s) == 1) begin
                m_cand = s; m_run = 1;
            end
            if (pop) void'(m_q.pop_front());
            if (push) begin
                if (m_q.size() < CAP) m_q.push_back(pc);
                else m_ovr = 1;
            end
        end
        m_p2 = m_p1;
        m_p1 = {btn_l, btn_d, btn_r, btn_u};
        if (m_prime < 2) m_prime++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge board_clk or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare and event recorder ----------------
    color_t ev_q[$];
    bit     busy_seen;

    initial begin
        forever begin
            @(negedge board_clk);
            if (!reset) begin
                chk("valid", evt_if.color_valid, (m_q.size() != 0));
                if (m_q.size() != 0) chk("code", evt_if.color_code, m_q[0]);
                chk("overrun", overrun, m_ovr);
                chk("busy", busy, (m_run > 0) || m_down);
                if (evt_if.color_valid && evt_if.color_ack) ev_q.push_back(evt_if.color_code);
                if (busy) busy_seen = 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge board_clk);
            #1;
        end
    endtask

    task automatic press_release(input int idx);
        case (idx)
            0: btn_u = 1'b1;
            1: btn_r = 1'b1;
            2: btn_d = 1'b1;
            default: btn_l = 1'b1;
        endcase
        cyc(12);
        {btn_l, btn_d, btn_r, btn_u} = 4'b0000;
        cyc(12);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int lat;
        evt_if.color_ack = 1'b0;
        busy_seen = 0;

        @(negedge board_clk);
        chk("rst_valid", evt_if.color_valid, 0);
        chk("rst_code", evt_if.color_code, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);
        cyc(1);
        reset = 1'b0;
        cyc(5);

        // Single clean press of R with ack held high.
        ev_q.delete();
        evt_if.color_ack = 1'b1;
        btn_r = 1'b1;
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge board_clk);
            @(negedge board_clk);
            if (evt_if.color_valid) begin lat = k; break; end
        end
        chk("latency_r", lat, 7);
        cyc(12);
        btn_r = 1'b0;
        cyc(15);
        chk("r_events", ev_q.size(), 1);
        if (ev_q.size() != 0) chk("r_code", ev_q[0], COLOR_R);

        // Bouncing U then stable.
        ev_q.delete();
        for (int i = 0; i < 8; i++) begin
            btn_u = (i % 2 == 0);
            cyc(1);
        end
        btn_u = 1'b1;
        cyc(3);
        chk("bounce_none", ev_q.size(), 0);
        cyc(17);
        btn_u = 1'b0;
        cyc(15);
        chk("u_events", ev_q.size(), 1);
        if (ev_q.size() != 0) chk("u_code", ev_q[0], COLOR_U);

        // Two buttons together: never qualifies.
        ev_q.delete();
        busy_seen = 0;
        btn_u = 1'b1;
        btn_l = 1'b1;
        cyc(20);
        btn_u = 1'b0;
        btn_l = 1'b0;
        cyc(10);
        chk("multi_busy", busy_seen, 0);
        chk("multi_events", ev_q.size(), 0);
        evt_if.color_ack = 1'b0;

`ifdef PUVVADA_BTN_FIFO_EN
        // Five presses into a depth-4 FIFO with no acks.
        press_release(0);
        press_release(1);
        press_release(2);
        press_release(3);
        press_release(0);
        chk("fifo_overrun", overrun, 1);
        for (int i = 0; i < 4; i++) begin
            chk("fifo_valid", evt_if.color_valid, 1);
            chk("fifo_code", evt_if.color_code, i);
            evt_if.color_ack = 1'b1;
            cyc(1);
            evt_if.color_ack = 1'b0;
        end
        chk("fifo_drained", evt_if.color_valid, 0);
`else
        // Holding register: second press dropped while first is pending.
        press_release(2);
        btn_l = 1'b1;
        cyc(12);
        chk("hold_valid", evt_if.color_valid, 1);
        chk("hold_code", evt_if.color_code, COLOR_D);
        chk("hold_overrun", overrun, 1);
        evt_if.color_ack = 1'b1;
        cyc(1);
        evt_if.color_ack = 1'b0;
        chk("hold_popped", evt_if.color_valid, 0);
        btn_l = 1'b0;
        cyc(12);
`endif
        enable = 1'b0;
        cyc(1);
        chk("dis_overrun", overrun, 0);
        enable = 1'b1;
        cyc(5);

        // Enable dropped with a pending event and button held.
        btn_r = 1'b1;
        cyc(12);
        chk("en_pending", evt_if.color_valid, 1);
        enable = 1'b0;
        cyc(1);
        chk("en_flushed", evt_if.color_valid, 0);
        enable = 1'b1;
        cyc(15);
        chk("en_held_valid", evt_if.color_valid, 0);
        chk("en_held_busy", busy, 0);
        btn_r = 1'b0;
        cyc(12);

        // Reset pulse while U is held.
        btn_u = 1'b1;
        cyc(10);
        chk("pre_rst_valid", evt_if.color_valid, 1);
        reset = 1'b1;
        #1;
        chk("midrst_valid", evt_if.color_valid, 0);
        chk("midrst_code", evt_if.color_code, 0);
        chk("midrst_overrun", overrun, 0);
        chk("midrst_busy", busy, 0);
        cyc(2);
        reset = 1'b0;
        ev_q.delete();
        busy_seen = 0;
        cyc(20);
        chk("postrst_valid", evt_if.color_valid, 0);
        chk("postrst_busy", busy_seen, 0);
        btn_u = 1'b0;
        cyc(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
